// File: rtl/alarm_bank.sv
// Multi-channel daily alarm controller: stores N_ALARMS hour/minute times, rings on match,
// supports snooze with a per-trigger limit, auto-timeout, and a debounced dismiss button.
// Ports: clk/rst, sec_tick + hour/minute/second from the timekeeper, mode/sel/set_*/load/clear
//   for programming, middle (raw button); outputs do_o (ringer), alarm_mode {setting,snoozing,
//   ringing}, active_ch, snooze_cnt, armed.  do_o is the ringer drive, registered.
module alarm_bank #(
   parameter int N_ALARMS        = 4,
   parameter int TW              = 11,
   parameter int DEBOUNCE_CYCLES = 1_000_000,
   parameter int RING_SECONDS    = 30,
   parameter int SNOOZE_SECONDS  = 300,
   parameter int MAX_SNOOZE      = 3,
   localparam int CW = (N_ALARMS > 1) ? $clog2(N_ALARMS) : 1,
   localparam int SW = (MAX_SNOOZE > 0) ? $clog2(MAX_SNOOZE + 1) : 1
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                sec_tick,
   input  logic [TW-1:0]       hour,
   input  logic [TW-1:0]       minute,
   input  logic [TW-1:0]       second,
   input  logic                mode,
   input  logic [CW-1:0]       sel,
   input  logic [TW-1:0]       set_hour,
   input  logic [TW-1:0]       set_minute,
   input  logic                load,
   input  logic                clear,
   input  logic                middle,
   output logic                do_o,
   output logic [2:0]          alarm_mode,
   output logic [CW-1:0]       active_ch,
   output logic [SW-1:0]       snooze_cnt,
   output logic [N_ALARMS-1:0] armed
);

   localparam int DW   = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
   localparam int TMAX = (RING_SECONDS > SNOOZE_SECONDS) ? RING_SECONDS : SNOOZE_SECONDS;
   localparam int TMW  = $clog2(TMAX + 1);

   typedef enum logic [1:0] {S_IDLE, S_RING, S_SNOOZE} state_t;

   state_t              state_q, state_d;
   logic                db_q, db_d;
   logic                db_prev_q, db_prev_d;
   logic                press_q, press_d;
   logic [DW-1:0]       db_cnt_q, db_cnt_d;
   logic [TMW-1:0]      timer_q, timer_d;
   logic [CW-1:0]       active_ch_q, active_ch_d;
   logic [SW-1:0]       snooze_cnt_q, snooze_cnt_d;
   logic [N_ALARMS-1:0] armed_q, armed_d;
   logic [TW-1:0]       alarm_h_q [N_ALARMS];
   logic [TW-1:0]       alarm_h_d [N_ALARMS];
   logic [TW-1:0]       alarm_m_q [N_ALARMS];
   logic [TW-1:0]       alarm_m_d [N_ALARMS];

   logic          sel_ok, do_clear, do_load, kill_active;
   logic          match_any, match;
   logic [CW-1:0] match_idx;

   always_comb begin
      db_d         = db_q;
      db_cnt_d     = '0;
      db_prev_d    = db_q;
      timer_d      = timer_q;
      active_ch_d  = active_ch_q;
      snooze_cnt_d = snooze_cnt_q;
      armed_d      = armed_q;
      alarm_h_d    = alarm_h_q;
      alarm_m_d    = alarm_m_q;
      state_d      = state_q;
      match_any    = 1'b0;
      match_idx    = '0;

      // Debounce: count consecutive cycles the raw button disagrees with the accepted level.
      if (middle != db_q) begin
         if (int'(db_cnt_q) == DEBOUNCE_CYCLES - 1) begin
            db_d = middle;
         end else begin
            db_cnt_d = db_cnt_q + DW'(1);
         end
      end
      // Rising edge of the accepted level, registered so it lands one cycle after the level.
      press_d = db_q & ~db_prev_q;

      // Programming; clear beats load when both are requested.
      sel_ok   = mode && (int'(sel) < N_ALARMS);
      do_clear = sel_ok && clear;
      do_load  = sel_ok && load && !clear;
      for (int i = 0; i < N_ALARMS; i++) begin
         if (sel == CW'(i)) begin
            if (do_clear) begin
               armed_d[i] = 1'b0;
            end else if (do_load) begin
               armed_d[i]   = 1'b1;
               alarm_h_d[i] = set_hour;
               alarm_m_d[i] = set_minute;
            end
         end
      end
      kill_active = do_clear && (sel == active_ch_q) && (state_q != S_IDLE);

      // Scan from the top so the lowest matching channel is the one left in match_idx.
      for (int i = N_ALARMS - 1; i >= 0; i--) begin
         if (armed_q[i] && hour == alarm_h_q[i] && minute == alarm_m_q[i]) begin
            match_any = 1'b1;
            match_idx = CW'(i);
         end
      end
      match = match_any && !mode && sec_tick && (second == '0);

      if (mode || kill_active) begin
         state_d = S_IDLE;
      end else begin
         case (state_q)
            S_IDLE: begin
               if (match) begin
                  state_d      = S_RING;
                  active_ch_d  = match_idx;
                  snooze_cnt_d = '0;
                  timer_d      = TMW'(RING_SECONDS);
               end
            end
            S_RING: begin
               if (press_q) begin
                  if (int'(snooze_cnt_q) < MAX_SNOOZE) begin
                     state_d      = S_SNOOZE;
                     snooze_cnt_d = snooze_cnt_q + SW'(1);
                     timer_d      = TMW'(SNOOZE_SECONDS);
                  end else begin
                     state_d = S_IDLE;
                  end
               end else if (sec_tick) begin
                  // Expire on the tick that takes the timer from 1 to 0.
                  timer_d = timer_q - TMW'(1);
                  if (timer_q <= TMW'(1)) begin
                     state_d = S_IDLE;
                  end
               end
            end
            S_SNOOZE: begin
               if (press_q) begin
                  state_d = S_IDLE;
               end else if (sec_tick) begin
                  timer_d = timer_q - TMW'(1);
                  if (timer_q <= TMW'(1)) begin
                     state_d = S_RING;
                     timer_d = TMW'(RING_SECONDS);
                  end
               end
            end
            default: state_d = S_IDLE;
         endcase
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q      <= S_IDLE;
         db_q         <= 1'b0;
         db_prev_q    <= 1'b0;
         press_q      <= 1'b0;
         db_cnt_q     <= '0;
         timer_q      <= '0;
         active_ch_q  <= '0;
         snooze_cnt_q <= '0;
         armed_q      <= '0;
         for (int i = 0; i < N_ALARMS; i++) begin
            alarm_h_q[i] <= '0;
            alarm_m_q[i] <= '0;
         end
      end else begin
         state_q      <= state_d;
         db_q         <= db_d;
         db_prev_q    <= db_prev_d;
         press_q      <= press_d;
         db_cnt_q     <= db_cnt_d;
         timer_q      <= timer_d;
         active_ch_q  <= active_ch_d;
         snooze_cnt_q <= snooze_cnt_d;
         armed_q      <= armed_d;
         alarm_h_q    <= alarm_h_d;
         alarm_m_q    <= alarm_m_d;
      end
   end

   assign do_o       = (state_q == S_RING);
   assign alarm_mode = {mode, state_q == S_SNOOZE, state_q == S_RING};
   assign active_ch  = active_ch_q;
   assign snooze_cnt = snooze_cnt_q;
   assign armed      = armed_q;

endmodule
